mul_iter: RTL and testbench



---
 rtl/mul_iter_if.sv | 24 ++
 rtl/mul_iter.sv | 108 ++++++++++
 tb/tb_mul_iter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_iter_if.sv
// Operand/result handshake bundle for mul_iter: operand side (a, b, in_valid,
// in_ready, abort) and product side (out, out_valid, out_ready).
interface mul_iter_if #(
  parameter int WIDTH = 58
);
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               in_valid;
  logic               in_ready;
  logic               abort;
  logic [2*WIDTH-1:0] out;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output a, b, in_valid, abort, out_ready,
    input  in_ready, out, out_valid
  );

  modport slave (
    input  a, b, in_valid, abort, out_ready,
    output in_ready, out, out_valid
  );
endinterface

// File: rtl/mul_iter.sv
// Multi-cycle unsigned multiplier: retires K multiplier bits per clock into a
// 2*WIDTH accumulator, with optional early exit once the remaining digits are zero.
module mul_iter #(
  parameter int WIDTH     = 58,
  parameter int K         = 2,
  parameter int EARLY_OUT = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  mul_iter_if.slave bus
);

  localparam int NCYC = (WIDTH + K - 1) / K;
  localparam int BW   = NCYC * K;
  localparam int AW   = 2 * WIDTH;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam int SW   = $clog2(AW) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NCYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0]   a_r;
  logic [BW-1:0]      b_r;
  logic [BW-1:0]      b_shift;
  logic [AW-1:0]      acc;
  logic [AW-1:0]      acc_nxt;
  logic [AW-1:0]      prod;
  logic [CW-1:0]      count;
  logic [WIDTH+K-1:0] pp;
  logic [SW-1:0]      shamt;
  logic               accept;
  logic               last;

  // With a single digit there is nothing left to shift in; avoid an empty slice.
  if (NCYC > 1) begin : g_shift
    assign b_shift = {{K{1'b0}}, b_r[BW-1:K]};
  end else begin : g_noshift
    assign b_shift = '0;
  end

  always_comb begin
    accept  = (state == IDLE) && bus.in_valid && !bus.abort;
    pp      = (WIDTH+K)'(a_r) * (WIDTH+K)'(b_r[K-1:0]);
    shamt   = SW'(count) * SW'(K);
    acc_nxt = acc + (AW'(pp) << shamt);
    last    = (count == LAST_CNT) || ((EARLY_OUT != 0) && (b_shift == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = RUN;
      end
      RUN: begin
        if (bus.abort)  state_nxt = IDLE;
        else if (last)  state_nxt = DONE;
      end
      DONE: begin
        if (bus.abort || bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.out       = prod;
  end

  // prod is only written on the final RUN step, so it survives abort and IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      acc   <= '0;
      count <= '0;
      prod  <= '0;
    end else if (accept) begin
      a_r   <= bus.a;
      b_r   <= BW'(bus.b);
      acc   <= '0;
      count <= '0;
    end else if ((state == RUN) && !bus.abort) begin
      acc   <= acc_nxt;
      b_r   <= b_shift;
      count <= count + CW'(1);
      if (last) prod <= acc_nxt;
    end
  end

endmodule

// File: tb/tb_mul_iter.sv
// Bench for mul_iter: directed cases on the default build (early-out on/off)
// plus a randomised sweep over width, digit size and early termination.
module tb_mul_iter;

  localparam int NDUT = 8;

  function automatic int cfg_w(int i);
    return (i >= 2 && i <= 4) ? 8 : 58;
  endfunction

  function automatic int cfg_k(int i);
    case (i)
      2, 5:    return 1;
      3, 6:    return 3;
      4:       return 8;
      7:       return 58;
      default: return 2;
    endcase
  endfunction

  function automatic int cfg_eo(int i);
    return (i == 1 || i == 5) ? 0 : 1;
  endfunction

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [57:0]  s_a     [NDUT];
  logic [57:0]  s_b     [NDUT];
  logic         s_iv    [NDUT];
  logic         s_abort [NDUT];
  logic         s_or    [NDUT];
  logic         s_ir    [NDUT];
  logic         s_ov    [NDUT];
  logic [115:0] s_out   [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int W  = cfg_w(g);
    localparam int KK = cfg_k(g);
    localparam int EO = cfg_eo(g);

    mul_iter_if #(.WIDTH(W)) mif ();

    assign mif.a         = s_a[g][W-1:0];
    assign mif.b         = s_b[g][W-1:0];
    assign mif.in_valid  = s_iv[g];
    assign mif.abort     = s_abort[g];
    assign mif.out_ready = s_or[g];
    assign s_ir[g]       = mif.in_ready;
    assign s_ov[g]       = mif.out_valid;
    assign s_out[g]      = 116'(mif.out);

    mul_iter #(.WIDTH(W), .K(KK), .EARLY_OUT(EO)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (mif.slave)
    );
  end

  typedef struct {
    int           cfg;
    logic [115:0] prod;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [115:0] obs, input logic [115:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic logic [57:0] wmask(int cfg);
    return (cfg_w(cfg) == 58) ? '1 : 58'hFF;
  endfunction

  // Cycle (handshake = 0) on which out_valid is first seen.
  function automatic int exp_cycle(int cfg, logic [57:0] b);
    int w    = cfg_w(cfg);
    int k    = cfg_k(cfg);
    int ncyc = (w + k - 1) / k;
    int bl   = 0;
    int n;
    for (int i = 0; i < w; i++) if (b[i]) bl = i + 1;
    if (cfg_eo(cfg) == 0) begin
      n = ncyc;
    end else begin
      n = (bl + k - 1) / k;
      if (n < 1) n = 1;
    end
    return n + 1;
  endfunction

  task automatic start_op(input int cfg, input logic [57:0] a, input logic [57:0] b);
    int t = 0;
    while (!s_ir[cfg] && t < 100) begin
      @(posedge clk); @(negedge clk);
      t++;
    end
    check("ready_before_start", 116'(s_ir[cfg]), 116'd1);
    s_a[cfg]  = a & wmask(cfg);
    s_b[cfg]  = b & wmask(cfg);
    s_iv[cfg] = 1'b1;
    @(posedge clk); @(negedge clk);
    s_iv[cfg] = 1'b0;
  endtask

  task automatic wait_valid(input int cfg, output int cyc);
    cyc = 1;
    while (!s_ov[cfg] && cyc < 200) begin
      @(posedge clk); @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_op(input string tag, input int cfg, input logic [57:0] a, input logic [57:0] b);
    exp_t        e;
    int          cyc;
    logic [57:0] am;
    logic [57:0] bm;
    am     = a & wmask(cfg);
    bm     = b & wmask(cfg);
    e.cfg  = cfg;
    e.prod = 116'(am) * 116'(bm);
    e.cyc  = exp_cycle(cfg, bm);
    sb.push_back(e);
    start_op(cfg, am, bm);
    wait_valid(cfg, cyc);
    e = sb.pop_front();
    check({tag, ".valid"}, 116'(s_ov[cfg]), 116'd1);
    check({tag, ".prod"},  s_out[cfg], e.prod);
    check({tag, ".cycle"}, 116'(cyc), 116'(e.cyc));
    @(posedge clk); @(negedge clk);
    check({tag, ".drop"}, 116'({s_ov[cfg], s_ir[cfg]}), 116'b01);
  endtask

  task automatic expect_quiet(input string tag, input int cfg, input int ncyc);
    logic seen = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); @(negedge clk);
      if (s_ov[cfg]) seen = 1'b1;
    end
    check(tag, 116'(seen), 116'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    logic [57:0] ra;
    logic [57:0] rb;

    for (int i = 0; i < NDUT; i++) begin
      s_a[i]     = '0;
      s_b[i]     = '0;
      s_iv[i]    = 1'b0;
      s_abort[i] = 1'b0;
      s_or[i]    = 1'b1;
    end

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.in_ready",  116'(s_ir[0]), 116'd1);
    check("reset.out_valid", 116'(s_ov[0]), 116'd0);
    check("reset.out",       s_out[0],      116'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Small operands, default build
    do_op("small_5x0",   0, 58'd5,  58'd0);
    do_op("small_2x1",   0, 58'd2,  58'd1);
    do_op("small_12x12", 0, 58'd12, 58'd12);

    // Reset mid-RUN discards the in-flight product
    start_op(0, '1, '1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid.in_ready",  116'(s_ir[0]), 116'd1);
    check("rst_mid.out_valid", 116'(s_ov[0]), 116'd0);
    check("rst_mid.out",       s_out[0],      116'd0);
    expect_quiet("rst_mid.no_stale", 0, 40);

    // Full-width operands, early-out on and off
    do_op("full_ones_eo1", 0, '1, '1);
    do_op("full_ones_eo0", 1, '1, '1);
    do_op("full_pat_eo1", 0, {2'b10, 56'hAAAAAAAAAAAAAA}, {2'b11, 56'h33333333333333});
    do_op("full_pat_eo0", 1, {2'b10, 56'hAAAAAAAAAAAAAA}, {2'b11, 56'h33333333333333});

    // Backpressure: product held, busy, in_valid ignored
    s_or[0] = 1'b0;
    start_op(0, 58'd12, 58'd12);
    wait_valid(0, cyc);
    check("bp.cycle", 116'(cyc), 116'd3);
    for (int i = 0; i < 5; i++) begin
      s_a[0]  = 58'd99;
      s_b[0]  = 58'd99;
      s_iv[0] = (i % 2) == 0;
      @(posedge clk); @(negedge clk);
      check("bp.valid", 116'(s_ov[0]), 116'd1);
      check("bp.out",   s_out[0],      116'd144);
      check("bp.ready", 116'(s_ir[0]), 116'd0);
    end
    s_iv[0] = 1'b0;
    s_or[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    check("bp.release", 116'({s_ov[0], s_ir[0]}), 116'b01);
    do_op("bp_next_3x4", 0, 58'd3, 58'd4);

    // Abort at RUN cycle 4 (no early-out so the op is still running)
    start_op(1, 58'd12, 58'd12);
    repeat (3) begin @(posedge clk); @(negedge clk); end
    s_abort[1] = 1'b1;
    @(posedge clk); @(negedge clk);
    s_abort[1] = 1'b0;
    check("abort_run.idle", 116'({s_ov[1], s_ir[1]}), 116'b01);
    expect_quiet("abort_run.no_valid", 1, 35);
    do_op("abort_next_7x9", 1, 58'd7, 58'd9);

    // Abort in DONE: out_valid drops, out keeps the last value
    s_or[0] = 1'b0;
    start_op(0, 58'd12, 58'd13);
    wait_valid(0, cyc);
    s_abort[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    s_abort[0] = 1'b0;
    s_or[0]    = 1'b1;
    check("abort_done.idle", 116'({s_ov[0], s_ir[0]}), 116'b01);
    check("abort_done.out",  s_out[0], 116'd156);

    // Abort has priority over in_valid in IDLE
    s_a[0]     = 58'd5;
    s_b[0]     = 58'd5;
    s_iv[0]    = 1'b1;
    s_abort[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    s_iv[0]    = 1'b0;
    s_abort[0] = 1'b0;
    check("abort_idle.not_taken", 116'(s_ir[0]), 116'd1);
    expect_quiet("abort_idle.no_valid", 0, 4);

    // Parameter sweep
    for (int c = 2; c < NDUT; c++) begin
      do_op($sformatf("sweep%0d_max", c),  c, '1, '1);
      do_op($sformatf("sweep%0d_zero", c), c, '1, '0);
      for (int n = 0; n < 150; n++) begin
        ra = 58'({$urandom(), $urandom()});
        rb = 58'({$urandom(), $urandom()}) >> $urandom_range(0, 58);
        do_op($sformatf("sweep%0d_rand%0d", c, n), c, ra, rb);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
